// File: rtl/mc_main_ctrl_if.sv
// Control bundle between the multicycle main-control FSM and the datapath.
// The controller (master) consumes the opcode and the memory handshake.
// It drives every datapath enable, the ALU opcode class and the status pulses.
interface mc_main_ctrl_if;
    logic [5:0] op;
    logic       mem_ready;
    logic       pcwrite;
    logic       pcwritecond;
    logic       branch_ne;
    logic [1:0] pcsrc;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [2:0] aluop;
    logic       retire;
    logic       illegal_op;
    logic       mem_timeout;
    logic [3:0] state;

    // Controller side
    modport master (
        input  op, mem_ready,
        output pcwrite, pcwritecond, branch_ne, pcsrc, iord, memread, memwrite,
               irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb, zeroext,
               aluop, retire, illegal_op, mem_timeout, state
    );

    // Datapath / memory side
    modport slave (
        output op, mem_ready,
        input  pcwrite, pcwritecond, branch_ne, pcsrc, iord, memread, memwrite,
               irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb, zeroext,
               aluop, retire, illegal_op, mem_timeout, state
    );
endinterface

// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS main control FSM.
// Sequences fetch / decode / execute / memory / writeback per opcode and drives
// the datapath enables plus the 3-bit aluop consumed by the downstream ALU-control
// decoder. Memory states stall on mem_ready, bounded by an 8-bit wait counter.
// Enables are Moore-decoded from the state register (FETCH additionally qualifies
// irwrite/pcwrite with mem_ready). retire, illegal_op and mem_timeout are
// registered one-cycle pulses aligned with the return to FETCH.
module mc_main_ctrl #(
    parameter bit HAS_BNE      = 1'b1,
    parameter int MEM_WAIT_MAX = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    mc_main_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_IEXEC  = 4'd11,
        S_IWB    = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    // The counter holds the number of stall cycles already spent, so the
    // MEM_WAIT_MAX-th stalled cycle is the one where it equals MEM_WAIT_MAX-1.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b100;

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       retire_q, retire_d;
    logic       illegal_q, illegal_d;
    logic       tmo_q, tmo_d;

    logic       mem_state;
    logic       stall;
    logic       limit_hit;

    // A memory state is stalled whenever its access has not completed this cycle.
    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign stall     = mem_state && !bus.mem_ready;
    assign limit_hit = stall && (wait_q == WAIT_LAST);

    // Counter is zero outside a stall, so it restarts on every entry to a memory
    // state and after a timeout (which re-enters FETCH).
    assign wait_d = (stall && !limit_hit) ? (wait_q + 8'd1) : 8'd0;

    // Next-state and pulse-request logic
    always_comb begin
        state_d   = state_q;
        retire_d  = 1'b0;
        illegal_d = 1'b0;
        tmo_d     = 1'b0;
        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                if (bus.mem_ready) begin
                    state_d = S_DECODE;
                end else if (limit_hit) begin
                    state_d = S_FETCH;
                    tmo_d   = 1'b1;
                end
            end
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW:             state_d = S_MEMADR;
                    OP_R:                     state_d = S_EXEC;
                    OP_BEQ:                   state_d = S_BRANCH;
                    OP_J:                     state_d = S_JUMP;
                    OP_ADDI, OP_ORI, OP_ANDI: state_d = S_IEXEC;
                    OP_BNE: begin
                        if (HAS_BNE) begin
                            state_d = S_BRANCH;
                        end else begin
                            state_d   = S_FETCH;
                            illegal_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (bus.mem_ready) begin
                    state_d = S_MEMWB;
                end else if (limit_hit) begin
                    state_d = S_FETCH;
                    tmo_d   = 1'b1;
                end
            end
            S_MEMWB: begin
                state_d  = S_FETCH;
                retire_d = 1'b1;
            end
            S_MEMWR: begin
                if (bus.mem_ready) begin
                    state_d  = S_FETCH;
                    retire_d = 1'b1;
                end else if (limit_hit) begin
                    state_d = S_FETCH;
                    tmo_d   = 1'b1;
                end
            end
            S_EXEC:  state_d = S_RWB;
            S_IEXEC: state_d = S_IWB;
            S_RWB, S_BRANCH, S_JUMP, S_IWB: begin
                state_d  = S_FETCH;
                retire_d = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State, wait counter and status pulses; async reset aborts any instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RST;
            wait_q    <= 8'd0;
            retire_q  <= 1'b0;
            illegal_q <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retire_q  <= retire_d;
            illegal_q <= illegal_d;
            tmo_q     <= tmo_d;
        end
    end

    // Moore decode of the datapath enables from the current state
    always_comb begin
        bus.pcwrite     = 1'b0;
        bus.pcwritecond = 1'b0;
        bus.branch_ne   = 1'b0;
        bus.pcsrc       = 2'b00;
        bus.iord        = 1'b0;
        bus.memread     = 1'b0;
        bus.memwrite    = 1'b0;
        bus.irwrite     = 1'b0;
        bus.regdst      = 1'b0;
        bus.memtoreg    = 1'b0;
        bus.regwrite    = 1'b0;
        bus.alusrca     = 1'b0;
        bus.alusrcb     = 2'b00;
        bus.zeroext     = 1'b0;
        bus.aluop       = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                bus.memread = 1'b1;
                bus.irwrite = bus.mem_ready;
                bus.pcwrite = bus.mem_ready;
                bus.alusrcb = 2'b01;
            end
            S_DECODE: bus.alusrcb = 2'b11;
            S_MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            S_MEMRD: begin
                bus.memread = 1'b1;
                bus.iord    = 1'b1;
            end
            S_MEMWB: begin
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
            end
            S_MEMWR: begin
                bus.memwrite = 1'b1;
                bus.iord     = 1'b1;
            end
            S_EXEC: begin
                bus.alusrca = 1'b1;
                bus.aluop   = ALU_FUNCT;
            end
            S_RWB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
            end
            S_BRANCH: begin
                bus.alusrca     = 1'b1;
                bus.aluop       = ALU_SUB;
                bus.pcwritecond = 1'b1;
                bus.pcsrc       = 2'b01;
                bus.branch_ne   = (bus.op == OP_BNE);
            end
            S_JUMP: begin
                bus.pcwrite = 1'b1;
                bus.pcsrc   = 2'b10;
            end
            S_IEXEC: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                case (bus.op)
                    OP_ORI: begin
                        bus.aluop   = ALU_OR;
                        bus.zeroext = 1'b1;
                    end
                    OP_ANDI: begin
                        bus.aluop   = ALU_AND;
                        bus.zeroext = 1'b1;
                    end
                    default: bus.aluop = ALU_ADD;
                endcase
            end
            S_IWB: bus.regwrite = 1'b1;
            default: ;
        endcase
    end

    assign bus.retire      = retire_q;
    assign bus.illegal_op  = illegal_q;
    assign bus.mem_timeout = tmo_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Scoreboard bench for mc_main_ctrl.
// Two instances: u_dut0 (HAS_BNE=1, MEM_WAIT_MAX=4) and u_dut1 (HAS_BNE=0).
// Stimulus pushes the hand-written expected output word for each cycle.
// The negedge monitor pops it and compares it with the selected instance.
module tb_mc_main_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic       pcwrite;
        logic       pcwritecond;
        logic       branch_ne;
        logic [1:0] pcsrc;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       zeroext;
        logic [2:0] aluop;
        logic       retire;
        logic       illegal_op;
        logic       mem_timeout;
    } outv_t;

    typedef struct {
        int    dut;
        int    n;
        outv_t e;
    } pkt_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op_r = 6'd0;
    logic       mr_r = 1'b0;
    logic       done = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         n_push = 0;
    pkt_t       q[$];
    outv_t      act0, act1;

    always #5 clk = ~clk;

    mc_main_ctrl_if if0 ();
    mc_main_ctrl_if if1 ();

    assign if0.op = op_r;
    assign if0.mem_ready = mr_r;
    assign if1.op = op_r;
    assign if1.mem_ready = mr_r;

    mc_main_ctrl #(.HAS_BNE(1'b1), .MEM_WAIT_MAX(4)) u_dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if0)
    );

    mc_main_ctrl #(.HAS_BNE(1'b0), .MEM_WAIT_MAX(255)) u_dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if1)
    );

    assign act0 = {if0.state, if0.pcwrite, if0.pcwritecond, if0.branch_ne, if0.pcsrc,
                   if0.iord, if0.memread, if0.memwrite, if0.irwrite, if0.regdst,
                   if0.memtoreg, if0.regwrite, if0.alusrca, if0.alusrcb, if0.zeroext,
                   if0.aluop, if0.retire, if0.illegal_op, if0.mem_timeout};
    assign act1 = {if1.state, if1.pcwrite, if1.pcwritecond, if1.branch_ne, if1.pcsrc,
                   if1.iord, if1.memread, if1.memwrite, if1.irwrite, if1.regdst,
                   if1.memtoreg, if1.regwrite, if1.alusrca, if1.alusrcb, if1.zeroext,
                   if1.aluop, if1.retire, if1.illegal_op, if1.mem_timeout};

    // Expected enables per state, with mem_ready low and no pulses
    function automatic outv_t exp_state(input int s);
        outv_t e;
        e    = '0;
        e.st = 4'(s);
        case (s)
            1:  begin e.memread = 1'b1; e.alusrcb = 2'b01; end
            2:  e.alusrcb = 2'b11;
            3:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            4:  begin e.memread = 1'b1; e.iord = 1'b1; end
            5:  begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
            6:  begin e.memwrite = 1'b1; e.iord = 1'b1; end
            7:  begin e.alusrca = 1'b1; e.aluop = 3'b010; end
            8:  begin e.regdst = 1'b1; e.regwrite = 1'b1; end
            9:  begin e.alusrca = 1'b1; e.aluop = 3'b001; e.pcwritecond = 1'b1; e.pcsrc = 2'b01; end
            10: begin e.pcwrite = 1'b1; e.pcsrc = 2'b10; end
            11: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            12: e.regwrite = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    // Drive one cycle of inputs and queue the outputs expected during that cycle
    task automatic step(input int d, input logic [5:0] o, input logic mr, input outv_t e);
        pkt_t p;
        op_r  = o;
        mr_r  = mr;
        p.dut = d;
        p.n   = n_push;
        p.e   = e;
        n_push++;
        q.push_back(p);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int d, input logic [5:0] o, input logic mr,
                         input logic ret, input logic ill, input logic tmo);
        outv_t e;
        e             = exp_state(1);
        e.irwrite     = mr;
        e.pcwrite     = mr;
        e.retire      = ret;
        e.illegal_op  = ill;
        e.mem_timeout = tmo;
        step(d, o, mr, e);
    endtask

    task automatic do_reset(input int d);
        rst_n = 1'b0;
        step(d, OP_R, 1'b0, exp_state(0));
        rst_n = 1'b1;
        step(d, OP_R, 1'b0, exp_state(0));
    endtask

    // Monitor: compare every queued expectation; final drain check and summary
    always @(negedge clk) begin
        pkt_t  p;
        outv_t a;
        if (done) begin
            checks++;
            if (q.size() != 0) begin
                errors++;
                $display("FAIL drain pending=%0d required=0", q.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end else if (q.size() > 0) begin
            p = q.pop_front();
            a = (p.dut == 1) ? act1 : act0;
            checks++;
            if (a !== p.e) begin
                errors++;
                $display("FAIL cyc%0d dut%0d state got %0d want %0d, outputs got %h want %h",
                         p.n, p.dut, a.st, p.e.st, a, p.e);
            end
        end
    end

    initial begin
        outv_t e;
        repeat (2) @(posedge clk);
        #1;
        do_reset(0);

        // R-type: FETCH, DECODE, EXEC, RWB, FETCH with retire
        fetch(0, OP_R, 1'b1, 1'b0, 1'b0, 1'b0);
        step(0, OP_R, 1'b1, exp_state(2));
        step(0, OP_R, 1'b1, exp_state(7));
        step(0, OP_R, 1'b1, exp_state(8));
        fetch(0, OP_R, 1'b1, 1'b1, 1'b0, 1'b0);

        // Async reset in EXEC: outputs clear before any clock edge
        step(0, OP_R, 1'b1, exp_state(2));
        rst_n = 1'b0;
        step(0, OP_R, 1'b1, exp_state(0));
        rst_n = 1'b1;
        step(0, OP_R, 1'b1, exp_state(0));

        // lw with two stall cycles in FETCH and in MEMRD
        fetch(0, OP_LW, 1'b0, 1'b0, 1'b0, 1'b0);
        fetch(0, OP_LW, 1'b0, 1'b0, 1'b0, 1'b0);
        fetch(0, OP_LW, 1'b1, 1'b0, 1'b0, 1'b0);
        step(0, OP_LW, 1'b1, exp_state(2));
        step(0, OP_LW, 1'b0, exp_state(3));
        step(0, OP_LW, 1'b0, exp_state(4));
        step(0, OP_LW, 1'b0, exp_state(4));
        step(0, OP_LW, 1'b1, exp_state(4));
        step(0, OP_LW, 1'b1, exp_state(5));
        fetch(0, OP_ORI, 1'b1, 1'b1, 1'b0, 1'b0);

        // ori: or + zero-extend, writeback to rt
        step(0, OP_ORI, 1'b1, exp_state(2));
        e = exp_state(11); e.aluop = 3'b011; e.zeroext = 1'b1;
        step(0, OP_ORI, 1'b1, e);
        step(0, OP_ORI, 1'b1, exp_state(12));
        fetch(0, OP_BNE, 1'b1, 1'b1, 1'b0, 1'b0);

        // bne: branch on not-zero
        step(0, OP_BNE, 1'b1, exp_state(2));
        e = exp_state(9); e.branch_ne = 1'b1;
        step(0, OP_BNE, 1'b1, e);
        fetch(0, OP_BEQ, 1'b1, 1'b1, 1'b0, 1'b0);

        // beq: branch on zero
        step(0, OP_BEQ, 1'b1, exp_state(2));
        step(0, OP_BEQ, 1'b1, exp_state(9));
        fetch(0, OP_J, 1'b1, 1'b1, 1'b0, 1'b0);

        // j
        step(0, OP_J, 1'b1, exp_state(2));
        step(0, OP_J, 1'b1, exp_state(10));
        fetch(0, OP_ANDI, 1'b1, 1'b1, 1'b0, 1'b0);

        // andi
        step(0, OP_ANDI, 1'b1, exp_state(2));
        e = exp_state(11); e.aluop = 3'b100; e.zeroext = 1'b1;
        step(0, OP_ANDI, 1'b1, e);
        step(0, OP_ANDI, 1'b1, exp_state(12));
        fetch(0, OP_BAD, 1'b1, 1'b1, 1'b0, 1'b0);

        // Unknown opcode: back to FETCH with illegal_op, no retire
        step(0, OP_BAD, 1'b1, exp_state(2));
        fetch(0, OP_SW, 1'b1, 1'b0, 1'b1, 1'b0);

        // sw stuck in MEMWR: timeout after 4 stall cycles, no retire
        step(0, OP_SW, 1'b1, exp_state(2));
        step(0, OP_SW, 1'b0, exp_state(3));
        step(0, OP_SW, 1'b0, exp_state(6));
        step(0, OP_SW, 1'b0, exp_state(6));
        step(0, OP_SW, 1'b0, exp_state(6));
        step(0, OP_SW, 1'b0, exp_state(6));
        fetch(0, OP_SW, 1'b1, 1'b0, 1'b0, 1'b1);

        // sw whose mem_ready arrives on the limit cycle: completes normally
        step(0, OP_SW, 1'b1, exp_state(2));
        step(0, OP_SW, 1'b0, exp_state(3));
        step(0, OP_SW, 1'b0, exp_state(6));
        step(0, OP_SW, 1'b0, exp_state(6));
        step(0, OP_SW, 1'b0, exp_state(6));
        step(0, OP_SW, 1'b1, exp_state(6));
        fetch(0, OP_R, 1'b1, 1'b1, 1'b0, 1'b0);

        // R-type then a FETCH that never gets mem_ready: timeout back into FETCH
        step(0, OP_R, 1'b1, exp_state(2));
        step(0, OP_R, 1'b1, exp_state(7));
        step(0, OP_R, 1'b0, exp_state(8));
        fetch(0, OP_R, 1'b0, 1'b1, 1'b0, 1'b0);
        fetch(0, OP_R, 1'b0, 1'b0, 1'b0, 1'b0);
        fetch(0, OP_R, 1'b0, 1'b0, 1'b0, 1'b0);
        fetch(0, OP_R, 1'b0, 1'b0, 1'b0, 1'b0);
        fetch(0, OP_R, 1'b0, 1'b0, 1'b0, 1'b1);
        fetch(0, OP_R, 1'b0, 1'b0, 1'b0, 1'b0);

        // HAS_BNE=0 instance: bne is illegal and never reaches BRANCH
        do_reset(1);
        fetch(1, OP_BNE, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1, OP_BNE, 1'b1, exp_state(2));
        fetch(1, OP_BNE, 1'b0, 1'b0, 1'b1, 1'b0);
        fetch(1, OP_BNE, 1'b0, 1'b0, 1'b0, 1'b0);

        done = 1'b1;
    end

endmodule
